// File: rtl/sqrt_square_recon.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sqrt_square_recon
//
// Rebuilds a 32-bit radicand from the result of the integer square-root block:
// num = root * root (+ rem), saturated at 32 bits. The square is formed by a
// 16-step iterative shift-add multiplier with valid/ready handshakes on both
// the operand side and the result side.
//
// Optional feature macro: SQRT_REM_EN
//   defined   : rem input and rem_err output exist, accumulator preloads rem,
//               ovf reports a sum that did not fit in 32 bits.
//   undefined : rem/rem_err are absent, accumulator preloads 0, ovf is tied 0
//               (root*root never exceeds 32'hFFFE_0001).
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   operand present
//   in_ready   out  1   block idle and able to take an operand
//   root       in  16   square root q (sampled only on the accept edge)
//   rem        in  17   remainder r (SQRT_REM_EN only, sampled on accept)
//   out_valid  out  1   num and flags valid
//   out_ready  in   1   downstream takes the result
//   num        out 32   reconstructed radicand, saturated
//   ovf        out  1   true sum exceeded 32 bits
//   rem_err    out  1   r > 2q, not a legal sqrt remainder (SQRT_REM_EN only)
//
// Timing: accept edge E0, shift-add steps on E1..E16, out_valid visible in the
// cycle after E16. in_ready/out_valid are decoded from the state register only.
// -----------------------------------------------------------------------------
module sqrt_square_recon (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] root,
`ifdef SQRT_REM_EN
  input  logic [16:0] rem,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] num,
  output logic        ovf
`ifdef SQRT_REM_EN
  ,
  output logic        rem_err
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r;
  logic [32:0] acc_r;     // 33 bits so the exact sum never wraps
  logic [31:0] mcand_r;   // multiplicand, shifted left every step
  logic [15:0] mplier_r;  // multiplier, shifted right every step
  logic [3:0]  cnt_r;     // step counter, last step at 15
  logic [31:0] num_r;
  logic        ovf_r;
  logic        rem_err_r;

  logic [32:0] acc_init_s;
  logic [32:0] acc_step_s;
  logic        rem_err_s;
  logic        last_step_s;
  logic [31:0] num_sat_s;

  // Accumulator preload and remainder legality check on the incoming operand
  always_comb begin
    acc_init_s = 33'd0;
    rem_err_s  = 1'b0;
`ifdef SQRT_REM_EN
    acc_init_s = {16'd0, rem};
    // A legal remainder satisfies r <= 2q; both sides are 17 bits wide
    if (rem > {root, 1'b0}) begin
      rem_err_s = 1'b1;
    end else begin
      rem_err_s = 1'b0;
    end
`endif
  end

  // One shift-add step: add the shifted multiplicand when the multiplier LSB is set
  always_comb begin
    acc_step_s = acc_r;
    if (mplier_r[0]) begin
      acc_step_s = acc_r + {1'b0, mcand_r};
    end else begin
      acc_step_s = acc_r;
    end
  end

  // Final-step detect and saturation of the value the accumulator is about to hold
  always_comb begin
    last_step_s = (cnt_r == 4'd15);
    num_sat_s   = acc_step_s[31:0];
    if (acc_step_s[32]) begin
      num_sat_s = 32'hFFFF_FFFF;
    end else begin
      num_sat_s = acc_step_s[31:0];
    end
  end

  // Control FSM: IDLE accepts, CALC runs 16 steps, DONE holds until drained
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            state_r <= CALC;
          end
        end
        CALC: begin
          if (last_step_s) begin
            state_r <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Multiplier datapath: load on accept, one shift-add step per CALC cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r    <= 33'd0;
      mcand_r  <= 32'd0;
      mplier_r <= 16'd0;
      cnt_r    <= 4'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            acc_r    <= acc_init_s;
            mcand_r  <= {16'd0, root};
            mplier_r <= root;
            cnt_r    <= 4'd0;
          end
        end
        CALC: begin
          acc_r    <= acc_step_s;
          mcand_r  <= {mcand_r[30:0], 1'b0};
          mplier_r <= {1'b0, mplier_r[15:1]};
          cnt_r    <= cnt_r + 4'd1;
        end
        DONE: begin
          acc_r <= acc_r;
        end
        default: begin
          acc_r <= acc_r;
        end
      endcase
    end
  end

  // Result registers: loaded on the last CALC step, held until the next result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_r <= 32'd0;
      ovf_r <= 1'b0;
    end else begin
      if ((state_r == CALC) && last_step_s) begin
        num_r <= num_sat_s;
        ovf_r <= acc_step_s[32];
      end
    end
  end

  // Remainder flag: captured with the operand so it describes the same result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_err_r <= 1'b0;
    end else begin
      if ((state_r == IDLE) && in_valid) begin
        rem_err_r <= rem_err_s;
      end
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign num       = num_r;

`ifdef SQRT_REM_EN
  assign ovf     = ovf_r;
  assign rem_err = rem_err_r;
`else
  // Without a remainder the square cannot overflow; these stay unobservable
  logic unused_s;
  assign unused_s = ovf_r ^ rem_err_r;
  assign ovf      = 1'b0;
`endif

endmodule

// File: doc/sqrt_square_recon.md
# sqrt_square_recon

Sequential inverse of the team's combinational 32-bit integer square-root block: it takes a 16-bit root (and, optionally, the 17-bit remainder) and rebuilds the original 32-bit radicand as root² + rem. It uses an iterative shift-add multiplier with valid/ready handshakes on both sides. In the Kalman datapath it sits on the checking and de-normalisation side of the sqrt unit. It is used to verify sqrt results in-system and to recover magnitudes from stored roots.

## Interface
Parameters:
- none. Widths are fixed to match the sqrt block: 32-bit radicand, 16-bit root, 17-bit remainder.

Ports:
- clk — input, 1 — single clock; all state changes on the rising edge.
- rst_n — input, 1 — asynchronous, active-low reset.
- in_valid — input, 1 — root (and rem) present.
- in_ready — output, 1 — block can accept an operand.
- root — input, 16 — square root q.
- rem — input, 17 — remainder r. Present only with SQRT_REM_EN.
- out_valid — output, 1 — num and flags are valid.
- out_ready — input, 1 — downstream accepts the result.
- num — output, 32 — reconstructed radicand q² + r, saturated.
- ovf — output, 1 — the true sum exceeded 32 bits.
- rem_err — output, 1 — r > 2q, so the input is not a legal sqrt remainder. Present only with SQRT_REM_EN.

## Operation
- FSM states:
  - IDLE: in_ready=1.
  - CALC: 16 iterations.
  - DONE: out_valid=1.
- Accept: on an edge with state IDLE and in_valid=1:
  - acc(33b) ← {16'b0, rem} with SQRT_REM_EN, otherwise 0.
  - mcand(32b) ← {16'b0, root}; mplier(16b) ← root; cnt ← 0.
  - rem_err ← (rem > {root,1'b0}).
  - state → CALC.
- CALC, each edge:
  - if mplier[0], acc ← acc + mcand.
  - mcand ← mcand<<1; mplier ← mplier>>1; cnt ← cnt+1.
  - At the edge where cnt==15, state → DONE.
- DONE entry: num ← acc[32] ? 32'hFFFF_FFFF : acc[31:0]; ovf ← acc[32].
- Output: on an edge with state DONE and out_ready=1, state → IDLE. num, ovf and rem_err hold their values until the next result is loaded.
- Arithmetic: exact unsigned arithmetic; the accumulator is 33 bits and never wraps.
  - For any legal pair (r ≤ 2q) the sum is ≤ 0xFFFF_FFFF, so ovf=0.
  - ovf can occur only with an illegal remainder.
- rem_err does not stop computation. The result is still produced.
- in_valid is ignored outside IDLE.
- root and rem are sampled only on the accept edge and need not be held afterwards.

## Timing
- Reset values:
  - state=IDLE, so in_ready=1.
  - out_valid=0, num=0, ovf=0, rem_err=0.
  - Internal acc, mcand, mplier and cnt are all 0.
- Latency: with the accept edge as E0, CALC runs on edges E1..E16 and out_valid rises after E16. It is visible in the cycle following E16.
- Throughput: the result drains on the first edge with out_ready=1. in_ready is 1 again in the next cycle. The minimum period is 18 cycles per operand.
- Backpressure: while out_ready=0, out_valid stays at 1 and num/flags are stable indefinitely.
- in_ready and out_valid are decoded from the state register only. There is no combinational path from in_valid or out_ready.
- Reset mid-operation, in any state: asynchronous return to the reset values. The in-flight operand is discarded and no partial result appears.

## Configuration
- SQRT_REM_EN defined:
  - the rem input and rem_err output exist.
  - The accumulator preloads rem, so num = q² + r, saturated, with ovf.
- SQRT_REM_EN undefined:
  - the rem and rem_err ports are absent and the accumulator preloads 0, so num = q².
  - ovf is still a port but is constant 0, since q² ≤ 0xFFFE_0001.

## Test plan
- Basic, with macro: root=3, rem=2 → num=11, ovf=0, rem_err=0, out_valid after E16.
- Max legal, with macro: root=0xFFFF, rem=0x1FFFE → num=0xFFFF_FFFF, ovf=0, rem_err=0.
- Illegal remainder, with macro: root=0xFFFF, rem=0x1FFFF → num=0xFFFF_FFFF, ovf=1, rem_err=1. Also root=2, rem=5 → num=9, rem_err=1, ovf=0.
- Backpressure: out_ready=0 for 10 cycles after out_valid → num stable, in_ready=0 throughout. A second in_valid pulse during CALC/DONE is ignored. It is accepted only after the drain edge.
- Reset mid-CALC: rst_n low at E8 → out_valid=0, num=0, in_ready=1 immediately. The next operand root=1000 gives num=1000000 with no residue.
- Without macro: root=0xFFFF → num=0xFFFE_0001, ovf=0. Random roots are checked against a q² reference and against the sqrt block round-trip.
